// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared pipeline control state encoding and counter width
package hazard_ctrl_pkg;
  typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, FREEZE = 2'd2} state_e;
  localparam int CNT_W = 16;
endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter: event counter that sticks at all-ones, with synchronous clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : (inc && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: RAW stall detection plus branch-flush / memory-freeze pipeline FSM
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       src1,
  input  logic [3:0]       src2,
  input  logic             Two_src,
  input  logic [3:0]       EXE_Dest,
  input  logic [3:0]       MEM_Dest,
  input  logic             EXE_WB_EN,
  input  logic             MEM_WB_EN,
  input  logic             EXE_MEM_R_EN,
  input  logic             fwd_en,
  input  logic             branch_taken,
  input  logic             mem_ready,
  input  logic             clr_cnt,
  output logic             hazard,
  output logic             flush,
  output logic             freeze,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  state_e state_q, state_d;
  logic   exe_hit, mem_hit, raw_hz;
  always_comb begin
    exe_hit = EXE_WB_EN && (src1 == EXE_Dest || (Two_src && src2 == EXE_Dest));
    mem_hit = MEM_WB_EN && (src1 == MEM_Dest || (Two_src && src2 == MEM_Dest));
    raw_hz  = fwd_en ? (EXE_MEM_R_EN && exe_hit) : (exe_hit || mem_hit);
    freeze  = !mem_ready;
    flush   = mem_ready && branch_taken && state_q != FLUSH;
    hazard  = raw_hz && mem_ready && !flush && state_q == RUN;
    // RUN and FREEZE share the same exits once memory is ready
    state_d = !mem_ready ? FREEZE : flush ? FLUSH : RUN;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= RUN;
    else state_q <= state_d;
  sat_counter #(.W(CNT_W)) u_stall (
    .clk(clk), .rst_n(rst), .inc(hazard), .clr(clr_cnt), .cnt(stall_cnt)
  );
  sat_counter #(.W(CNT_W)) u_flush (
    .clk(clk), .rst_n(rst), .inc(flush), .clr(clr_cnt), .cnt(flush_cnt)
  );
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of stall, flush, freeze and counters
module tb_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  src1, src2, EXE_Dest, MEM_Dest;
  logic        Two_src, EXE_WB_EN, MEM_WB_EN, EXE_MEM_R_EN, fwd_en;
  logic        branch_taken, mem_ready, clr_cnt;
  logic        hazard, flush, freeze;
  logic [15:0] stall_cnt, flush_cnt;
  int checks = 0;
  int failures = 0;

  hazard_ctrl dut (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .Two_src(Two_src),
    .EXE_Dest(EXE_Dest), .MEM_Dest(MEM_Dest), .EXE_WB_EN(EXE_WB_EN),
    .MEM_WB_EN(MEM_WB_EN), .EXE_MEM_R_EN(EXE_MEM_R_EN), .fwd_en(fwd_en),
    .branch_taken(branch_taken), .mem_ready(mem_ready), .clr_cnt(clr_cnt),
    .hazard(hazard), .flush(flush), .freeze(freeze),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    src1 = 4'd1; src2 = 4'd2; Two_src = 1'b0; EXE_Dest = 4'd7; MEM_Dest = 4'd8;
    EXE_WB_EN = 1'b0; MEM_WB_EN = 1'b0; EXE_MEM_R_EN = 1'b0; fwd_en = 1'b0;
    branch_taken = 1'b0; mem_ready = 1'b1; clr_cnt = 1'b0;
  endtask

  task automatic clear_counters();
    idle();
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
  endtask

  task automatic chk_out(input string name, input logic eh, input logic ef, input logic ez);
    checks++;
    if (hazard !== eh || flush !== ef || freeze !== ez) begin
      failures++;
      $display("FAIL %s hazard/flush/freeze=%b%b%b expected %b%b%b", name, hazard, flush, freeze, eh, ef, ez);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    #1;
    chk_out("reset_idle", 1'b0, 1'b0, 1'b0);
    checks++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_cnt stall=%h flush=%h expected 0 0", stall_cnt, flush_cnt);
    end
    src1 = 4'd3; EXE_Dest = 4'd3; EXE_WB_EN = 1'b1;
    #1;
    chk_out("reset_comb_hazard", 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    checks++;
    if (stall_cnt !== 16'd0) begin
      failures++;
      $display("FAIL reset_no_count stall=%h expected 0", stall_cnt);
    end
    mem_ready = 1'b0;
    #1;
    chk_out("reset_freeze", 1'b0, 1'b0, 1'b1);
    idle();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_raw();
    clear_counters();
    src1 = 4'd3; EXE_Dest = 4'd3; EXE_WB_EN = 1'b1;
    #1;
    chk_out("raw_exe", 1'b1, 1'b0, 1'b0);
    tick(); tick(); tick();
    checks++;
    if (stall_cnt !== 16'd3) begin
      failures++;
      $display("FAIL raw_stall_cnt stall=%0d expected 3", stall_cnt);
    end
    EXE_WB_EN = 1'b0;
    #1;
    chk_out("raw_exe_no_wb", 1'b0, 1'b0, 1'b0);
    MEM_Dest = 4'd3; MEM_WB_EN = 1'b1;
    #1;
    chk_out("raw_mem", 1'b1, 1'b0, 1'b0);
    fwd_en = 1'b1;
    #1;
    chk_out("raw_mem_fwd", 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    src2 = 4'd9; MEM_Dest = 4'd9; MEM_WB_EN = 1'b1;
    #1;
    chk_out("raw_src2_single", 1'b0, 1'b0, 1'b0);
    Two_src = 1'b1;
    #1;
    chk_out("raw_src2_two", 1'b1, 1'b0, 1'b0);
    tick();
    idle();
    src1 = 4'd15; MEM_Dest = 4'd15; MEM_WB_EN = 1'b1;
    #1;
    chk_out("raw_pc", 1'b1, 1'b0, 1'b0);
    src1 = 4'd14;
    #1;
    chk_out("raw_pc_miss", 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_fwd();
    idle();
    fwd_en = 1'b1; src2 = 4'd5; Two_src = 1'b1; EXE_Dest = 4'd5; EXE_WB_EN = 1'b1;
    #1;
    chk_out("fwd_no_load", 1'b0, 1'b0, 1'b0);
    EXE_MEM_R_EN = 1'b1;
    #1;
    chk_out("fwd_load_use", 1'b1, 1'b0, 1'b0);
    Two_src = 1'b0;
    #1;
    chk_out("fwd_single_src", 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_branch();
    clear_counters();
    src1 = 4'd3; EXE_Dest = 4'd3; EXE_WB_EN = 1'b1; branch_taken = 1'b1;
    #1;
    chk_out("br_run", 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("br_flush_state", 1'b0, 1'b0, 1'b0);
    checks++;
    if (flush_cnt !== 16'd1) begin
      failures++;
      $display("FAIL br_flush_cnt flush_cnt=%0d expected 1", flush_cnt);
    end
    tick();
    branch_taken = 1'b0;
    #1;
    chk_out("br_back_run", 1'b1, 1'b0, 1'b0);
    checks++;
    if (flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
      failures++;
      $display("FAIL br_counts flush=%0d stall=%0d expected 1 0", flush_cnt, stall_cnt);
    end
    tick();
  endtask

  task automatic test_freeze();
    clear_counters();
    src1 = 4'd3; EXE_Dest = 4'd3; EXE_WB_EN = 1'b1;
    mem_ready = 1'b0; branch_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk_out($sformatf("frz_cycle%0d", i), 1'b0, 1'b0, 1'b1);
      tick();
    end
    mem_ready = 1'b1;
    #1;
    chk_out("frz_ready_flush", 1'b0, 1'b1, 1'b0);
    tick();
    chk_out("frz_then_flush_state", 1'b0, 1'b0, 1'b0);
    checks++;
    if (flush_cnt !== 16'd1 || stall_cnt !== 16'd0) begin
      failures++;
      $display("FAIL frz_counts flush=%0d stall=%0d expected 1 0", flush_cnt, stall_cnt);
    end
    mem_ready = 1'b0;
    #1;
    chk_out("flush_to_freeze", 1'b0, 1'b0, 1'b1);
    tick();
    mem_ready = 1'b1; branch_taken = 1'b0;
    #1;
    chk_out("freeze_to_run", 1'b0, 1'b0, 1'b0);
    tick();
    #1;
    chk_out("run_after_freeze", 1'b1, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_saturate();
    clear_counters();
    src1 = 4'd3; EXE_Dest = 4'd3; EXE_WB_EN = 1'b1;
    for (int i = 0; i < 65534; i++) tick();
    checks++;
    if (stall_cnt !== 16'hFFFE) begin
      failures++;
      $display("FAIL sat_preload stall=%h expected fffe", stall_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (stall_cnt !== 16'hFFFF) begin
        failures++;
        $display("FAIL sat_hold%0d stall=%h expected ffff", i, stall_cnt);
      end
    end
    clr_cnt = 1'b1;
    #1;
    chk_out("sat_clr_hazard", 1'b1, 1'b0, 1'b0);
    tick();
    clr_cnt = 1'b0;
    checks++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      failures++;
      $display("FAIL sat_clr stall=%h flush=%h expected 0 0", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_async_reset();
    clear_counters();
    src1 = 4'd3; EXE_Dest = 4'd3; EXE_WB_EN = 1'b1;
    tick(); tick();
    branch_taken = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    checks++;
    if (stall_cnt !== 16'd2 || flush_cnt !== 16'd1) begin
      failures++;
      $display("FAIL arst_pre stall=%0d flush=%0d expected 2 1", stall_cnt, flush_cnt);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      failures++;
      $display("FAIL arst_cnt stall=%h flush=%h expected 0 0", stall_cnt, flush_cnt);
    end
    mem_ready = 1'b1; branch_taken = 1'b0;
    #1;
    chk_out("arst_state_run", 1'b1, 1'b0, 1'b0);
    #1;
    rst = 1'b1;
    tick();
    checks++;
    if (stall_cnt !== 16'd1) begin
      failures++;
      $display("FAIL arst_resume stall=%0d expected 1", stall_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_fwd();
    test_branch();
    test_freeze();
    test_saturate();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 clk  in  1  single rising-edge clock.
REQ-002 rst  in  1  asynchronous, active-low reset.
REQ-003 src1, src2  in  4 each  ID-stage source register numbers.
REQ-004 Two_src  in  1  src2 is a real operand.
REQ-005 EXE_Dest, MEM_Dest  in  4 each  destination registers in EXE and MEM.
REQ-006 EXE_WB_EN, MEM_WB_EN  in  1 each  write-back enables in EXE and MEM.
REQ-007 EXE_MEM_R_EN  in  1  EXE holds a load.
REQ-008 fwd_en  in  1  forwarding unit active.
REQ-009 branch_taken  in  1  branch resolved taken in EXE.
REQ-010 mem_ready  in  1  data memory ready; 0 freezes the pipeline.
REQ-011 clr_cnt  in  1  synchronous clear of both counters.
REQ-012 hazard  out  1  stall IF and the IF/ID register, and insert a bubble into ID/EX.
REQ-013 flush  out  1  clear the IF/ID and ID/EX registers at the next edge.
REQ-014 freeze  out  1  hold every pipeline register.
REQ-015 stall_cnt, flush_cnt  out  16 each  saturating event counters.

Function
REQ-016 raw_hz is combinational and defined as follows:
- fwd_en=0: src1 matches EXE_Dest with EXE_WB_EN=1 or MEM_Dest with MEM_WB_EN=1; src2 matches under the same conditions only when Two_src=1.
- fwd_en=1: the same test applies with EXE terms only and additionally gated by EXE_MEM_R_EN=1 (load-use); MEM terms are ignored.
REQ-017 The FSM has states RUN, FLUSH, FREEZE; the reset state is RUN.
REQ-018 RUN transitions, highest priority first:
- mem_ready=0 -> FREEZE.
- otherwise branch_taken=1 -> FLUSH.
- otherwise stay in RUN.
REQ-019 FLUSH lasts exactly one cycle and then goes to FREEZE if mem_ready=0, otherwise to RUN.
REQ-020 FREEZE remains while mem_ready=0; when mem_ready=1 it goes to FLUSH if branch_taken=1, otherwise to RUN.
REQ-021 freeze = ~mem_ready in every state, combinational, with zero latency.
REQ-022 flush = mem_ready & branch_taken in state RUN or FREEZE, and 0 in state FLUSH; a branch seen during a freeze therefore flushes in the first ready cycle.
REQ-023 hazard = raw_hz & mem_ready & ~flush & (state==RUN), combinational; it is always 0 in FLUSH because ID holds a bubble.
REQ-024 hazard, flush and freeze are mutually exclusive in every cycle.
REQ-025 stall_cnt increments at each edge where hazard=1; flush_cnt increments at each edge where flush=1; both saturate at 16'hFFFF.
REQ-026 When clr_cnt=1, both counters are loaded with 0 at the next edge, overriding any increment in that cycle.
REQ-027 A register number of 15 (PC) is compared like any other register; no special casing.

Reset
REQ-028 While rst=0: state=RUN, stall_cnt=0, flush_cnt=0, independent of clk.
REQ-029 Outputs during reset follow the combinational rules from state RUN; the counters do not count until the first edge after rst deasserts.
REQ-030 Reset asserted mid-FREEZE or mid-FLUSH returns the FSM to RUN immediately; a pending branch is discarded.

Structure
REQ-031 The state encoding (2-bit constants RUN=0, FLUSH=1, FREEZE=2) and the counter width (16) belong in the shared pipeline package.
REQ-032 One sub-module, sat_counter (parameterised width, with inc, clr and async active-low rst), is instantiated twice.
REQ-033 The FSM and the raw_hz compare logic are implemented in hazard_ctrl itself.

Verification
REQ-034 fwd_en=0, src1=3, EXE_Dest=3, EXE_WB_EN=1, mem_ready=1 -> hazard=1 and stall_cnt +1 per cycle held.
REQ-035 fwd_en=1, src2=5, Two_src=1, EXE_Dest=5, EXE_WB_EN=1, EXE_MEM_R_EN=0 -> hazard=0; with EXE_MEM_R_EN=1 -> hazard=1; with Two_src=0 -> hazard=0.
REQ-036 branch_taken=1 and raw_hz=1 in RUN -> flush=1, hazard=0, flush_cnt=1; the next cycle is FLUSH with flush=0 and hazard=0, then RUN.
REQ-037 mem_ready=0 for 4 cycles with branch_taken=1 -> freeze=1 and flush=0 for 4 cycles, then flush=1 in the first ready cycle, then FLUSH.
REQ-038 stall_cnt preloaded to 16'hFFFE, hazard held 3 cycles -> 16'hFFFF stays; clr_cnt=1 together with hazard=1 -> 0.
REQ-039 rst pulled low mid-FREEZE, asynchronous to clk -> state=RUN and both counters=0 before the next edge.
